sram_arbiter: RTL and testbench

Two-port arbiter that shares one single-ported SRAM_wrapper instance between two requesters, for example the CPU data port and a DMA/loader engine. It grants at most one access per cycle using round-robin priority, with an optional lock that keeps ownership across a read-modify-write sequence. It drives the SRAM control, address and data pins and routes each read response back to the requester that issued it.

---
 rtl/sram_arbiter.sv | 121 ++++++++++++
 tb/tb_sram_arbiter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
// Round-robin arbiter sharing one single-ported SRAM between two masters,
// with bounded ownership locking and per-master read-response routing.
module sram_arbiter #(
    parameter int AW       = 14,
    parameter int DW       = 32,
    parameter int MAX_LOCK = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          m0_req,
    input  logic          m1_req,
    input  logic          m0_lock,
    input  logic          m1_lock,
    input  logic [3:0]    m0_we,
    input  logic [3:0]    m1_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m0_wdata,
    input  logic [DW-1:0] m1_wdata,
    output logic          m0_gnt,
    output logic          m1_gnt,
    output logic          m0_rvalid,
    output logic          m1_rvalid,
    output logic [DW-1:0] m0_rdata,
    output logic [DW-1:0] m1_rdata,
    output logic          sram_cs,
    output logic          sram_oe,
    output logic [3:0]    sram_web,
    output logic [AW-1:0] sram_a,
    output logic [DW-1:0] sram_di,
    input  logic [DW-1:0] sram_do
);

    localparam logic [3:0] LOCK_MAX = 4'(MAX_LOCK);

    logic          last;
    logic          owner_lock;
    logic          owner;
    logic [2:0]    lock_cnt;
    logic          rd_pend;
    logic          rd_id;

    logic          sel;
    logic          gnt_any;
    logic          sel_lock;
    logic [3:0]    sel_we;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;
    logic [3:0]    cnt_inc;
    logic          lock_hit;

    always_comb begin
        sel     = 1'b0;
        gnt_any = 1'b0;
        if (owner_lock) begin
            sel     = owner;
            gnt_any = owner ? m1_req : m0_req;
        end else if (m0_req && m1_req) begin
            sel     = ~last;
            gnt_any = 1'b1;
        end else begin
            sel     = m1_req;
            gnt_any = m0_req | m1_req;
        end
        // Nothing may reach the SRAM while reset is held.
        if (!rst) gnt_any = 1'b0;
    end

    assign sel_lock  = sel ? m1_lock  : m0_lock;
    assign sel_we    = sel ? m1_we    : m0_we;
    assign sel_addr  = sel ? m1_addr  : m0_addr;
    assign sel_wdata = sel ? m1_wdata : m0_wdata;

    assign cnt_inc  = {1'b0, lock_cnt} + 4'd1;
    assign lock_hit = (cnt_inc >= LOCK_MAX);

    assign m0_gnt = gnt_any & ~sel;
    assign m1_gnt = gnt_any & sel;

    assign sram_cs  = gnt_any;
    assign sram_oe  = gnt_any && (sel_we == 4'h0);
    assign sram_web = gnt_any ? ~sel_we : 4'hF;
    assign sram_a   = gnt_any ? sel_addr : '0;
    assign sram_di  = gnt_any ? sel_wdata : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last       <= 1'b1;
            owner_lock <= 1'b0;
            owner      <= 1'b0;
            lock_cnt   <= 3'd0;
            rd_pend    <= 1'b0;
            rd_id      <= 1'b0;
        end else begin
            rd_pend <= gnt_any && (sel_we == 4'h0);
            rd_id   <= sel;
            if (gnt_any) begin
                last <= sel;
                // The grant that reaches MAX_LOCK releases ownership.
                if (sel_lock && !lock_hit) begin
                    owner_lock <= 1'b1;
                    owner      <= sel;
                    lock_cnt   <= cnt_inc[2:0];
                end else begin
                    owner_lock <= 1'b0;
                    lock_cnt   <= 3'd0;
                end
            end else if (owner_lock) begin
                owner_lock <= 1'b0;
                lock_cnt   <= 3'd0;
                last       <= owner;
            end
        end
    end

    assign m0_rvalid = rd_pend & ~rd_id;
    assign m1_rvalid = rd_pend & rd_id;
    assign m0_rdata  = m0_rvalid ? sram_do : '0;
    assign m1_rdata  = m1_rvalid ? sram_do : '0;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a small behavioural SRAM
// attached to the SRAM pins.
module tb_sram_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req, m1_req, m0_lock, m1_lock;
    logic [3:0]  m0_we, m1_we;
    logic [13:0] m0_addr, m1_addr;
    logic [31:0] m0_wdata, m1_wdata;
    logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata;
    logic        sram_cs, sram_oe;
    logic [3:0]  sram_web;
    logic [13:0] sram_a;
    logic [31:0] sram_di;
    logic [31:0] sram_do;

    logic [31:0] mem [0:255];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    sram_arbiter #(.AW(14), .DW(32), .MAX_LOCK(4)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m1_req(m1_req),
        .m0_lock(m0_lock), .m1_lock(m1_lock),
        .m0_we(m0_we), .m1_we(m1_we),
        .m0_addr(m0_addr), .m1_addr(m1_addr),
        .m0_wdata(m0_wdata), .m1_wdata(m1_wdata),
        .m0_gnt(m0_gnt), .m1_gnt(m1_gnt),
        .m0_rvalid(m0_rvalid), .m1_rvalid(m1_rvalid),
        .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
        .sram_cs(sram_cs), .sram_oe(sram_oe),
        .sram_web(sram_web), .sram_a(sram_a),
        .sram_di(sram_di), .sram_do(sram_do)
    );

    always @(posedge clk) begin
        if (sram_cs) begin
            for (int b = 0; b < 4; b++)
                if (!sram_web[b])
                    mem[sram_a[7:0]][8*b +: 8] <= sram_di[8*b +: 8];
            if (sram_oe) sram_do <= mem[sram_a[7:0]];
        end
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle();
        m0_req = 0; m1_req = 0; m0_lock = 0; m1_lock = 0;
        m0_we = 0; m1_we = 0; m0_addr = 0; m1_addr = 0;
        m0_wdata = 0; m1_wdata = 0;
    endtask

    task automatic check_reset_outs(input string tag);
        check({tag, " gnt"}, {m1_gnt, m0_gnt}, 2'b00);
        check({tag, " rvalid"}, {m1_rvalid, m0_rvalid}, 2'b00);
        check({tag, " rdata"}, {m1_rdata, m0_rdata}, 64'h0);
        check({tag, " sram ctl"}, {sram_cs, sram_oe, sram_web}, {2'b00, 4'hF});
        check({tag, " sram a/di"}, {sram_a, sram_di}, 46'h0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 0;
        idle();
        @(negedge clk);
        @(negedge clk);
        rst = 1;
    endtask

    logic [1:0] exp_cont [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
    logic [1:0] exp_lock [6] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b10};

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 + i;
        mem[8'h10] = 32'hDEADBEEF;
        mem[8'h20] = 32'hAABBCCDD;
        mem[8'h01] = 32'h0101_0101;
        mem[8'h02] = 32'h0202_0202;
        sram_do = 0;
        rst = 0;
        idle();
        #2;
        check_reset_outs("reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1;

        // Single read by m0
        @(negedge clk);
        m0_req = 1; m0_addr = 14'h10;
        #1;
        check("rd gnt", {m1_gnt, m0_gnt}, 2'b01);
        check("rd ctl", {sram_cs, sram_oe, sram_web}, {2'b11, 4'hF});
        check("rd addr", sram_a, 14'h10);
        @(negedge clk);
        idle();
        #1;
        check("rd rvalid", {m1_rvalid, m0_rvalid}, 2'b01);
        check("rd data", m0_rdata, 32'hDEADBEEF);

        // Byte write by m1 then read back
        @(negedge clk);
        m1_req = 1; m1_we = 4'b0011; m1_wdata = 32'h12345678;
        m1_addr = 14'h20;
        #1;
        check("wr gnt", {m1_gnt, m0_gnt}, 2'b10);
        check("wr web/oe", {sram_web, sram_oe}, {4'b1100, 1'b0});
        @(negedge clk);
        m1_we = 0; m1_wdata = 0;
        #1;
        check("wr no rvalid", {m1_rvalid, m0_rvalid}, 2'b00);
        @(negedge clk);
        idle();
        #1;
        check("wr rb valid", {m1_rvalid, m0_rvalid}, 2'b10);
        check("wr rb low", m1_rdata[15:0], 16'h5678);
        check("wr rb word", m1_rdata, 32'hAABB5678);

        // Contention from reset
        do_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            m0_req = 1; m1_req = 1;
            #1;
            check($sformatf("cont %0d", i), {m1_gnt, m0_gnt}, exp_cont[i]);
        end
        @(negedge clk);
        idle();

        // Make m0 the most recent grant, then m1 locks while m0 waits
        m0_req = 1; m0_we = 4'hF;
        @(negedge clk);
        idle();
        for (int i = 0; i < 6; i++) begin
            m0_req = 1; m0_we = 4'hF; m0_addr = 14'h40;
            m1_req = 1; m1_lock = 1; m1_we = 4'hF; m1_addr = 14'h41;
            #1;
            check($sformatf("lock %0d", i), {m1_gnt, m0_gnt}, exp_lock[i]);
            @(negedge clk);
        end
        idle();
        @(negedge clk);

        // Both lock with contention from reset: m0 wins and keeps it
        do_reset();
        @(negedge clk);
        m0_req = 1; m1_req = 1; m0_lock = 1; m1_lock = 1;
        m0_we = 4'hF; m1_we = 4'hF;
        #1;
        check("dlock 0", {m1_gnt, m0_gnt}, 2'b01);
        @(negedge clk);
        #1;
        check("dlock 1", {m1_gnt, m0_gnt}, 2'b01);
        @(negedge clk);
        idle();
        @(negedge clk);

        // Back-to-back alternating reads
        @(negedge clk);
        m0_req = 1; m0_addr = 14'h1;
        #1;
        check("b2b gnt0", {m1_gnt, m0_gnt}, 2'b01);
        @(negedge clk);
        idle();
        m1_req = 1; m1_addr = 14'h2;
        #1;
        check("b2b gnt1", {m1_gnt, m0_gnt}, 2'b10);
        check("b2b rv0", {m1_rvalid, m0_rvalid}, 2'b01);
        check("b2b d0", m0_rdata, 32'h0101_0101);
        @(negedge clk);
        idle();
        #1;
        check("b2b rv1", {m1_rvalid, m0_rvalid}, 2'b10);
        check("b2b d1", {m1_rdata, m0_rdata}, {32'h0202_0202, 32'h0});

        // Reset asserted the cycle after a read grant
        @(negedge clk);
        m0_req = 1; m0_addr = 14'h10;
        #1;
        check("rst rd gnt", m0_gnt, 1'b1);
        @(negedge clk);
        idle();
        rst = 0;
        #1;
        check_reset_outs("rst mid");
        @(negedge clk);
        rst = 1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            #1;
            check_reset_outs($sformatf("rst post %0d", i));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
